i2c_target: RTL

I2C target (slave) responder with 7-bit device address, 16-bit register pointer and 8-bit data. It is the bus end opposite our I2C initiator and sits in the ToF driver simulation and bring-up path. It models a ToF sensor register map, or exposes FPGA registers to an external I2C master. It oversamples SCL/SDA on the system clock and converts bus transactions into single-cycle register read/write strobes.

---
 rtl/i2c_pkg.sv | 26 ++
 rtl/i2c_line_sync.sv | 61 ++++++
 rtl/i2c_target.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, ACK/NACK bus levels and field widths.
package i2c_pkg;

  localparam int ADDR_W = 7;   // device address width
  localparam int PTR_W  = 16;  // register pointer width
  localparam int DATA_W = 8;   // data byte width

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    DEV_ADDR,
    DEV_ACK,
    PTR_HI,
    ACK_HI,
    PTR_LO,
    ACK_LO,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers plus registered SCL edge and START/STOP strobes.
// The sda output is aligned with the strobes, so it is the SDA level at the
// moment an SCL edge is reported.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync_reg;
  logic [SYNC_STAGES-1:0] sda_sync_reg;
  logic                   scl_prev_reg;
  logic                   sda_prev_reg;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_rise_reg;
  logic                   scl_fall_reg;
  logic                   start_reg;
  logic                   stop_reg;

  assign scl_s = scl_sync_reg[SYNC_STAGES-1];
  assign sda_s = sda_sync_reg[SYNC_STAGES-1];

  // Synchronizer chains (idle bus is high) and registered edge/condition strobes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
      scl_prev_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
      scl_rise_reg <= 1'b0;
      scl_fall_reg <= 1'b0;
      start_reg    <= 1'b0;
      stop_reg     <= 1'b0;
    end else begin
      scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl_in};
      sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_in};
      scl_prev_reg <= scl_s;
      sda_prev_reg <= sda_s;
      scl_rise_reg <= scl_s & ~scl_prev_reg;
      scl_fall_reg <= ~scl_s & scl_prev_reg;
      start_reg    <= scl_s & scl_prev_reg & sda_prev_reg & ~sda_s;
      stop_reg     <= scl_s & scl_prev_reg & ~sda_prev_reg & sda_s;
    end
  end

  assign sda      = sda_prev_reg;
  assign scl_rise = scl_rise_reg;
  assign scl_fall = scl_fall_reg;
  assign start    = start_reg;
  assign stop     = stop_reg;

endmodule

// File: rtl/i2c_target.sv
// I2C target: 7-bit address, 16-bit auto-incrementing register pointer,
// 8-bit data, exposed as single-cycle register read/write strobes.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SLAVE_ADDRESS = 7'h29,
  parameter int                SYNC_STAGES   = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              SCL_in,
  input  logic              SDA_in,
  output logic              SDA_out,
  output logic              SDA_t,
  output logic [PTR_W-1:0]  reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy,
  output logic              error_out
);

  logic sda, scl_rise, scl_fall, start, stop;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clock    (clock),
    .reset_n  (reset_n),
    .scl_in   (SCL_in),
    .sda_in   (SDA_in),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              high_reg, high_next;   // a bit was sampled and SCL has not fallen yet
  logic [DATA_W-1:0] rx_reg, rx_next;
  logic [DATA_W-1:0] tx_reg, tx_next;
  logic [PTR_W-1:0]  ptr_reg, ptr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              rw_reg, rw_next;
  logic              wr_reg, wr_next;
  logic              rd_reg, rd_next;
  logic              sda_t_reg, sda_t_next;
  logic              busy_reg, busy_next;
  logic              err_reg, err_next;
  logic [DATA_W-1:0] rx_byte;
  logic              receiving;

  assign rx_byte   = {rx_reg[DATA_W-2:0], sda};
  assign receiving = (state_reg == DEV_ADDR) || (state_reg == PTR_HI) ||
                     (state_reg == PTR_LO)   || (state_reg == WR_DATA);

  // State and datapath registers; reset releases SDA immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      high_reg  <= 1'b0;
      rx_reg    <= '0;
      tx_reg    <= '0;
      ptr_reg   <= '0;
      wdata_reg <= '0;
      rw_reg    <= 1'b0;
      wr_reg    <= 1'b0;
      rd_reg    <= 1'b0;
      sda_t_reg <= 1'b1;
      busy_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      high_reg  <= high_next;
      rx_reg    <= rx_next;
      tx_reg    <= tx_next;
      ptr_reg   <= ptr_next;
      wdata_reg <= wdata_next;
      rw_reg    <= rw_next;
      wr_reg    <= wr_next;
      rd_reg    <= rd_next;
      sda_t_reg <= sda_t_next;
      busy_reg  <= busy_next;
      err_reg   <= err_next;
    end
  end

  // Next-state and strobe logic; START/STOP outrank any SCL edge in the same cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    high_next  = high_reg;
    rx_next    = rx_reg;
    tx_next    = tx_reg;
    ptr_next   = ptr_reg;
    wdata_next = wdata_reg;
    rw_next    = rw_reg;
    wr_next    = 1'b0;
    rd_next    = 1'b0;
    sda_t_next = sda_t_reg;
    busy_next  = busy_reg;
    err_next   = 1'b0;

    // Read data arrives one cycle after the request; pointer advances after a write.
    if (rd_reg) tx_next = reg_rdata;
    if (wr_reg) ptr_next = ptr_reg + 16'd1;

    if (start || stop) begin
      // The bit sampled on the SCL rise just before a START/STOP is not a real bit.
      if (receiving && (cnt_reg > {3'b000, high_reg})) err_next = 1'b1;
      cnt_next = '0;
      if (start) begin
        state_next = DEV_ADDR;
        busy_next  = 1'b1;
      end else begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    end else if (scl_rise) begin
      high_next = 1'b1;
      case (state_reg)
        DEV_ADDR, PTR_HI, PTR_LO, WR_DATA: begin
          rx_next  = rx_byte;
          cnt_next = cnt_reg + 4'd1;
          if (cnt_reg == 4'd7) begin
            cnt_next = '0;
            case (state_reg)
              DEV_ADDR: begin
                if (rx_byte[DATA_W-1:1] == SLAVE_ADDRESS) begin
                  rw_next    = rx_byte[0];
                  rd_next    = rx_byte[0];   // prefetch the first read byte
                  state_next = DEV_ACK;
                end else begin
                  state_next = WAIT_STOP;
                end
              end
              PTR_HI: begin
                ptr_next[15:8] = rx_byte;
                state_next     = ACK_HI;
              end
              PTR_LO: begin
                ptr_next[7:0] = rx_byte;
                state_next    = ACK_LO;
              end
              default: begin
                wr_next    = 1'b1;
                wdata_next = rx_byte;
                state_next = WR_ACK;
              end
            endcase
          end
        end
        DEV_ACK: state_next = rw_reg ? RD_DATA : PTR_HI;
        ACK_HI:  state_next = PTR_LO;
        ACK_LO:  state_next = WR_DATA;
        WR_ACK:  state_next = WR_DATA;
        RD_DATA: begin
          cnt_next = cnt_reg + 4'd1;
          if (cnt_reg == 4'd7) begin
            cnt_next   = '0;
            state_next = RD_ACK;
          end
        end
        RD_ACK: begin
          ptr_next = ptr_reg + 16'd1;
          if (sda == I2C_ACK) begin
            rd_next    = 1'b1;
            state_next = RD_DATA;
          end else begin
            state_next = WAIT_STOP;
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      high_next = 1'b0;
      case (state_reg)
        DEV_ACK, ACK_HI, ACK_LO, WR_ACK: sda_t_next = I2C_ACK;
        RD_DATA: begin
          sda_t_next = tx_reg[DATA_W-1];
          tx_next    = {tx_reg[DATA_W-2:0], 1'b0};
        end
        default: sda_t_next = 1'b1;
      endcase
    end
  end

  assign SDA_out   = 1'b0;
  assign SDA_t     = sda_t_reg;
  assign reg_addr  = ptr_reg;
  assign reg_wdata = wdata_reg;
  assign reg_wr    = wr_reg;
  assign reg_rd    = rd_reg;
  assign busy      = busy_reg;
  assign error_out = err_reg;

endmodule
